// File: rtl/memory_arbiter.sv
// Single-port memory arbiter between fetch (read-only) and load/store; misaligned fetches become two locked reads.
// Optional: define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin on contention (default: data over fetch).
`timescale 1ns/1ps

module memory_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_rdata,

  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  input  logic [3:0]            data_wmask,
  output logic                  data_ready,
  output logic                  data_valid,
  output logic [31:0]           data_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic {IDLE, SPLIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA, OWN_SPLIT} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  resp_write_q, resp_write_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           half_q, half_d;
  logic                  last_fetch_q, last_fetch_d;
  logic                  grant_fetch, grant_data;

  logic [ADDR_WIDTH-1:0] fetch_word, data_word;
  assign fetch_word = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
  assign data_word  = {data_addr[ADDR_WIDTH-1:2], 2'b00};

  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[0], data_addr[1:0]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = OWN_NONE;
    resp_write_d = 1'b0;
    base_d       = base_q;
    half_d       = half_q;
    last_fetch_d = last_fetch_q;
    grant_fetch  = 1'b0;
    grant_data   = 1'b0;
    fetch_ready  = 1'b0;
    data_ready   = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;

    case (state_q)
      IDLE: begin
        if (data_req && fetch_req) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          grant_data  = last_fetch_q;
          grant_fetch = !last_fetch_q;
`else
          grant_data  = 1'b1;
`endif
        end else begin
          grant_data  = data_req;
          grant_fetch = fetch_req;
        end

        if (grant_data) begin
          data_ready   = 1'b1;
          mem_en       = 1'b1;
          mem_we       = data_we;
          mem_addr     = data_word;
          mem_wdata    = data_wdata;
          mem_wmask    = data_wmask;
          owner_d      = OWN_DATA;
          resp_write_d = data_we;
          last_fetch_d = 1'b0;
        end else if (grant_fetch) begin
          fetch_ready  = 1'b1;
          mem_en       = 1'b1;
          mem_addr     = fetch_word;
          last_fetch_d = 1'b1;
          if (fetch_addr[1]) begin
            // Beat 0 data is consumed internally next cycle, not returned.
            state_d = SPLIT;
            base_d  = fetch_word;
          end else begin
            owner_d = OWN_FETCH;
          end
        end
      end

      SPLIT: begin
        mem_en   = 1'b1;
        mem_addr = base_q + ADDR_WIDTH'(4);
        half_d   = mem_rdata[31:16];
        owner_d  = OWN_SPLIT;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      resp_write_q <= 1'b0;
      base_q       <= '0;
      half_q       <= '0;
      last_fetch_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      resp_write_q <= resp_write_d;
      base_q       <= base_d;
      half_q       <= half_d;
      last_fetch_q <= last_fetch_d;
    end
  end

  always_comb begin
    fetch_valid = 1'b0;
    fetch_rdata = '0;
    data_valid  = 1'b0;
    data_rdata  = '0;
    case (owner_q)
      OWN_FETCH: begin
        fetch_valid = 1'b1;
        fetch_rdata = mem_rdata;
      end
      OWN_SPLIT: begin
        fetch_valid = 1'b1;
        fetch_rdata = {mem_rdata[15:0], half_q};
      end
      OWN_DATA: begin
        data_valid = 1'b1;
        data_rdata = resp_write_q ? 32'h0 : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected responses, a monitor pops and compares them.
`timescale 1ns/1ps

module tb_memory_arbiter;
  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ready, fetch_valid;
  logic [31:0]   fetch_rdata;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [31:0]   data_wdata = '0;
  logic [3:0]    data_wmask = '0;
  logic          data_ready, data_valid;
  logic [31:0]   data_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;

  memory_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wmask(data_wmask), .data_ready(data_ready),
    .data_valid(data_valid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: one-cycle read latency, byte-masked writes, preload port for setup.
  logic [31:0] mem [256];
  logic [31:0] mem_rdata_r;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  assign mem_rdata = mem_rdata_r;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_wmask);
      else        mem_rdata_r <= mem[mem_addr[9:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] rdata; int at; } exp_t;
  exp_t fq[$];
  exp_t dq[$];
  exp_t me;

  // Monitor: every valid pulse must match the oldest expectation, at the expected cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (fetch_valid) begin
        if (fq.size() == 0) check("fetch_valid_unexpected", 32'(fetch_valid), 32'h0);
        else begin
          me = fq.pop_front();
          check("fetch_rdata", fetch_rdata, me.rdata);
          check("fetch_valid_cycle", 32'(cyc), 32'(me.at));
        end
      end else check("fetch_rdata_idle_zero", fetch_rdata, 32'h0);
      if (data_valid) begin
        if (dq.size() == 0) check("data_valid_unexpected", 32'(data_valid), 32'h0);
        else begin
          me = dq.pop_front();
          check("data_rdata", data_rdata, me.rdata);
          check("data_valid_cycle", 32'(cyc), 32'(me.at));
        end
      end else check("data_rdata_idle_zero", data_rdata, 32'h0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    pl_en  = 1'b1;
    pl_idx = a[9:2];
    pl_val = v;
    step();
    pl_en  = 1'b0;
  endtask

  // Leaves the caller at the falling edge of the grant cycle.
  task automatic wait_fetch_grant(output int n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (fetch_ready) begin n = cyc; return; end
      step();
    end
    check("fetch_ready_timeout", 32'h0, 32'h1);
    n = cyc;
  endtask

  task automatic wait_data_grant(output int n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (data_ready) begin n = cyc; return; end
      step();
    end
    check("data_ready_timeout", 32'h0, 32'h1);
    n = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n, m;
    logic exp_d;

    preload(32'h0000_0010, 32'h00A0_0093);
    preload(32'h0000_0014, 32'h1234_4585);
    preload(32'h0000_0030, 32'h0000_D001);
    preload(32'h0000_0040, 32'h0000_F001);
    preload(32'hFFFF_FFFC, 32'hCAFE_0000);
    preload(32'h0000_0000, 32'h0000_1234);

    @(negedge clock);
    check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    check("rst_data_valid",  32'(data_valid),  32'h0);
    check("rst_mem_en",      32'(mem_en),      32'h0);
    check("rst_fetch_rdata", fetch_rdata,      32'h0);
    check("rst_data_rdata",  data_rdata,       32'h0);
    step();
    reset_n = 1'b1;
    step();

    // Aligned fetch
    fetch_addr = 32'h0000_0010;
    fetch_req  = 1'b1;
    wait_fetch_grant(n);
    check("al_mem_en",   32'(mem_en), 32'h1);
    check("al_mem_we",   32'(mem_we), 32'h0);
    check("al_mem_addr", mem_addr,    32'h0000_0010);
    fq.push_back('{32'h00A0_0093, n + 1});
    step();
    fetch_req = 1'b0;
    step();
    step();

    // Misaligned fetch: two beats, stitched result
    preload(32'h0000_0010, 32'h4501_AAAA);
    fetch_addr = 32'h0000_0012;
    fetch_req  = 1'b1;
    wait_fetch_grant(n);
    check("mis_beat0_addr", mem_addr, 32'h0000_0010);
    fq.push_back('{32'h4585_4501, n + 2});
    step();
    fetch_req = 1'b0;
    @(negedge clock);
    check("mis_beat1_en",    32'(mem_en),      32'h1);
    check("mis_beat1_addr",  mem_addr,         32'h0000_0014);
    check("mis_beat1_ready", 32'(fetch_ready), 32'h0);
    step();
    step();

    // Contention for four cycles
    data_addr  = 32'h0000_0030;
    data_we    = 1'b0;
    fetch_addr = 32'h0000_0040;
    data_req   = 1'b1;
    fetch_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check("arb_data_ready",  32'(data_ready),  32'(exp_d));
      check("arb_fetch_ready", 32'(fetch_ready), 32'(!exp_d));
      if (exp_d) dq.push_back('{32'h0000_D001, cyc + 1});
      else       fq.push_back('{32'h0000_F001, cyc + 1});
      step();
    end
    data_req  = 1'b0;
    fetch_req = 1'b0;
    step();
    step();

    // Data write arriving during SPLIT waits one cycle
    fetch_addr = 32'h0000_0012;
    fetch_req  = 1'b1;
    wait_fetch_grant(n);
    fq.push_back('{32'h4585_4501, n + 2});
    step();
    fetch_req  = 1'b0;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 32'h0000_0020;
    data_wdata = 32'hDEAD_BEEF;
    data_wmask = 4'hF;
    @(negedge clock);
    check("split_data_ready_held", 32'(data_ready), 32'h0);
    step();
    wait_data_grant(m);
    check("split_data_grant_cycle", 32'(m), 32'(n + 2));
    check("wr_mem_we",    32'(mem_we), 32'h1);
    check("wr_mem_addr",  mem_addr,    32'h0000_0020);
    check("wr_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
    check("wr_mem_wmask", 32'(mem_wmask), 32'hF);
    dq.push_back('{32'h0, m + 1});
    step();
    data_req = 1'b0;
    data_we  = 1'b0;
    step();
    data_req = 1'b1;
    wait_data_grant(m);
    dq.push_back('{32'hDEAD_BEEF, m + 1});
    step();
    data_req = 1'b0;
    step();
    step();

    // Misaligned fetch at the top of the address space wraps beat 1 to zero
    fetch_addr = 32'hFFFF_FFFE;
    fetch_req  = 1'b1;
    wait_fetch_grant(n);
    check("wrap_beat0_addr", mem_addr, 32'hFFFF_FFFC);
    fq.push_back('{32'h1234_CAFE, n + 2});
    step();
    fetch_req = 1'b0;
    @(negedge clock);
    check("wrap_beat1_addr", mem_addr, 32'h0000_0000);
    step();
    step();

    // Reset in the middle of a split discards the response
    fetch_addr = 32'h0000_0012;
    fetch_req  = 1'b1;
    wait_fetch_grant(n);
    step();
    fetch_req = 1'b0;
    reset_n   = 1'b0;
    @(negedge clock);
    check("rst_split_fetch_valid", 32'(fetch_valid), 32'h0);
    check("rst_split_fetch_rdata", fetch_rdata,      32'h0);
    check("rst_split_mem_en",      32'(mem_en),      32'h0);
    check("rst_split_mem_addr",    mem_addr,         32'h0);
    check("rst_split_data_valid",  32'(data_valid),  32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    step();

    fetch_addr = 32'h0000_0014;
    fetch_req  = 1'b1;
    wait_fetch_grant(n);
    check("post_rst_mem_addr", mem_addr, 32'h0000_0014);
    fq.push_back('{32'h1234_4585, n + 1});
    step();
    fetch_req = 1'b0;
    step();
    step();
    step();

    check("fetch_queue_drained", 32'(fq.size()), 32'h0);
    check("data_queue_drained",  32'(dq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
